// File: rtl/divider_control_if.sv
// Controller <-> request logic / restoring-divider datapath signal bundle.
//   master : the controller (drives datapath controls and status)
//   slave  : the environment (request logic + datapath)
//   start     - division request
//   divisorin - divisor bus (controller only tests it for zero)
//   sign      - datapath adder result bit 7
//   load/add/shift/inbit/sel - datapath controls
//   busy/done/err            - status
interface divider_control_if;
    localparam int unsigned DIVISOR_W = 7;
    localparam int unsigned SEL_W     = 2;

    logic                 start;
    logic [DIVISOR_W-1:0] divisorin;
    logic                 sign;
    logic                 load;
    logic                 add;
    logic                 shift;
    logic                 inbit;
    logic [SEL_W-1:0]     sel;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        input  start, divisorin, sign,
        output load, add, shift, inbit, sel, busy, done, err
    );

    modport slave (
        output start, divisorin, sign,
        input  load, add, shift, inbit, sel, busy, done, err
    );
endinterface

// File: rtl/divider_control.sv
// Sequencer for the 8-bit / 7-bit restoring divider datapath.
// One load step, then N_BITS subtract/decide iterations, then a one-cycle
// done pulse. Divide-by-zero is caught at load and reported on err.
// Ports:
//   clk   - rising-edge clock shared with the datapath
//   reset - synchronous active-high reset
//   dp    - divider_control_if.master (request, datapath controls, status)
module divider_control #(
    parameter int unsigned N_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    divider_control_if.master        dp
);
    localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

    localparam logic [1:0] SEL_ADDER = 2'b01;
    localparam logic [1:0] SEL_INIT  = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SUB    = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic       load;
        logic       add;
        logic       shift;
        logic       inbit;
        logic [1:0] sel;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;
    logic             err_q;
    logic             zero_q;
    ctrl_t            ctrl_q;

    // Control word for a state; neg only matters in DECIDE (restore vs keep).
    function automatic ctrl_t ctrl_of(state_t s, logic neg);
        ctrl_t c;
        c = '{load: 1'b0, add: 1'b0, shift: 1'b0, inbit: 1'b0,
              sel: SEL_HOLD, busy: 1'b0, done: 1'b0};
        case (s)
            LOAD: begin
                c.load  = 1'b1;
                c.sel   = SEL_INIT;
                c.shift = 1'b1;
                c.busy  = 1'b1;
            end
            SUB: begin
                c.sel  = SEL_ADDER;
                c.busy = 1'b1;
            end
            DECIDE: begin
                c.shift = 1'b1;
                c.busy  = 1'b1;
                if (neg) begin
                    c.sel = SEL_ADDER;
                    c.add = 1'b1;
                end else begin
                    c.inbit = 1'b1;
                end
            end
            DONE:    c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Sequencer: controls are registered from the state being entered, so
    // no input reaches an output without passing through a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            ctrl_q  <= ctrl_of(IDLE, 1'b0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (dp.start) begin
                        state_q <= LOAD;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        zero_q  <= (dp.divisorin == '0);
                        ctrl_q  <= ctrl_of(LOAD, neg_q);
                    end else begin
                        ctrl_q  <= ctrl_of(IDLE, neg_q);
                    end
                end
                LOAD: begin
                    if (zero_q) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        ctrl_q  <= ctrl_of(DONE, neg_q);
                    end else begin
                        state_q <= SUB;
                        ctrl_q  <= ctrl_of(SUB, neg_q);
                    end
                end
                SUB: begin
                    // Latch the trial-subtraction sign; DECIDE is decoded from it.
                    neg_q   <= dp.sign;
                    state_q <= DECIDE;
                    ctrl_q  <= ctrl_of(DECIDE, dp.sign);
                end
                DECIDE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        ctrl_q  <= ctrl_of(DONE, neg_q);
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= SUB;
                        ctrl_q  <= ctrl_of(SUB, neg_q);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ctrl_q  <= ctrl_of(IDLE, neg_q);
                end
                default: begin
                    state_q <= IDLE;
                    ctrl_q  <= ctrl_of(IDLE, neg_q);
                end
            endcase
        end
    end

    assign dp.load  = ctrl_q.load;
    assign dp.add   = ctrl_q.add;
    assign dp.shift = ctrl_q.shift;
    assign dp.inbit = ctrl_q.inbit;
    assign dp.sel   = ctrl_q.sel;
    assign dp.busy  = ctrl_q.busy;
    assign dp.done  = ctrl_q.done;
    assign dp.err   = err_q;

endmodule

// File: doc/divider_control.md
# divider_control

Sequencing FSM for the 8-bit-dividend / 7-bit-divisor restoring divider datapath. On a start request it drives the datapath's `load`, `add`, `shift`, `inbit` and `sel` controls through one load step and eight subtract/decide iterations, using the datapath `sign` flag. It reports completion with a one-cycle `done` pulse and holds the result stable until the next start. It sits between the system request logic and the datapath and is the only block that drives the datapath controls.

## Interface
- `N_BITS`, default 8: quotient bits, which is also the number of iterations. Counter width is `$clog2(N_BITS)`.
- `clk` input, 1 bit: rising-edge clock, shared with the datapath.
- `reset` input, 1 bit: synchronous, active-high reset, clock `clk`.
- `start` input, 1 bit: request a division. Sampled only in IDLE.
- `divisorin` input, 7 bits: same bus the datapath sees. Used only for zero detection, sampled when `start` is accepted.
- `sign` input, 1 bit: datapath adder result bit 7.
- `load` output, 1 bit: datapath divisor register load.
- `add` output, 1 bit: 1 = add, 0 = subtract.
- `shift` output, 1 bit: shift the remainder-register input left by 1.
- `inbit` output, 1 bit: LSB shifted in.
- `sel` output, 2 bits: datapath mux select. Only 2'b01, 2'b10 and 2'b11 are legal; this block never drives 2'b00.
- `busy` output, 1 bit: high in LOAD, SUB and DECIDE.
- `done` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: divide-by-zero flag.

## Operation
- States: IDLE, LOAD, SUB, DECIDE, DONE.
- Registers: state, iteration counter `cnt`, registered sign `neg_q`, `err`.
- Datapath controls are decoded from state and `neg_q` only. There is no combinational path from `start` or `sign` to any output.
- **IDLE**: `sel=11`, `shift=0`, `load=0`, `add=0`, `inbit=0`.
  - `start=1` → LOAD; clear `err`; `cnt←0`.
  - If `divisorin==0`, set an internal zero flag.
- **LOAD**: `load=1`, `sel=10`, `shift=1`, `inbit=0`. Datapath captures divisor and {8'h00, dividend}<<1.
  - Zero flag set → DONE with `err←1`.
  - Otherwise → SUB.
- **SUB**: `sel=01`, `add=0`, `shift=0`. Upper half ← upper − divisor. `neg_q←sign` at the end of the cycle. → DECIDE.
- **DECIDE** (outputs depend on `neg_q`):
  - `neg_q=1` (restore): `sel=01`, `add=1`, `shift=1`, `inbit=0`.
  - `neg_q=0`: `sel=11`, `add=0`, `shift=1`, `inbit=1`.
  - If `cnt==N_BITS-1` → DONE; otherwise `cnt←cnt+1` and → SUB.
- **DONE**: hold controls as in IDLE; `done=1`. → IDLE unconditionally.
- Results are read as quotient = rem[7:0] and remainder = rem[15:9]. They stay valid from the DONE cycle until the LOAD of the next accepted start.
- `err` is a level signal. It is set on entry to DONE for a zero divisor and cleared when the next `start` is accepted. When `err=1`, quotient and remainder are undefined.
- `start` while not in IDLE (including DONE) is ignored. There is no queueing.
- `reset` in any state → IDLE next edge. `cnt=0`, `neg_q=0`, `err=0`. A divide in progress is abandoned.

## Timing
- Reset values: `load=0`, `add=0`, `shift=0`, `inbit=0`, `sel=11`, `busy=0`, `done=0`, `err=0`.
- Start is accepted at edge E0. Cycle k is the interval after edge Ek.
  - LOAD occupies cycle 1.
  - SUB occupies cycles 2, 4, …, 16; DECIDE occupies cycles 3, 5, …, 17.
  - DONE occupies cycle 18.
  - Latency from start to `done` is 2·N_BITS+2 cycles (18 for N_BITS=8).
- Zero divisor: LOAD in cycle 1, DONE in cycle 2, `err=1` from cycle 2.
- `busy` is high in cycles 1–17 and low in DONE.
- Earliest back-to-back start: `start` sampled in the IDLE cycle after DONE, giving a new LOAD two cycles after the `done` pulse.
- `neg_q` is captured only at the end of SUB. `sign` is a don't-care in all other states.

## Test plan
- 200/7, with `start` pulsed at E0: `done` in cycle 18, quotient=28, remainder=4, `err=0`. Check the exact `sel`/`add`/`shift`/`inbit` trace against the per-state table.
- Run 255/1, 5/9, 0/13 and 127/127: (q,r) = (255,0), (0,5), (0,0), (1,0). DECIDE must follow the restore path on every iteration for 5/9.
- 100/0: `done` in cycle 2, `err=1`. On the next start of 100/3, `err` clears at acceptance, and the result is q=33, r=1 with `err=0`.
- `start` held high continuously: divisions complete back-to-back, each `done` is one cycle wide, and no start is accepted during the DONE cycle.
- `reset` asserted in cycle 9 of a divide: all outputs at reset values next cycle and `busy=0`. A subsequent 50/6 gives q=8, r=2.
- Over the whole run, `sel` is never 2'b00, and `load` is high only in LOAD.
